iotdf_avg_filter: RTL and testbench

IOTDF_AVG_FILTER -- requirements
Module: iotdf_avg_filter

---
 rtl/iotdf_pkg.sv | 14 +
 rtl/iotdf_acc.sv | 51 +++++
 rtl/iotdf_avg_filter.sv | 117 +++++++++++
 tb/tb_iotdf_avg_filter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/iotdf_pkg.sv
// -----------------------------------------------------------------------------
// iotdf_pkg
// Shared constants for the IOTDF averaging filter.
//   IOTDF_DATA_W_DEF : default sample / result width in bits
//   IOTDF_LOG2_N_DEF : default log2 of the group size N
//   IOTDF_GCNT_W     : width of the completed-group counter
// -----------------------------------------------------------------------------
package iotdf_pkg;

   localparam int IOTDF_DATA_W_DEF = 128;
   localparam int IOTDF_LOG2_N_DEF = 3;
   localparam int IOTDF_GCNT_W     = 8;

endpackage : iotdf_pkg

// File: rtl/iotdf_acc.sv
// -----------------------------------------------------------------------------
// iotdf_acc
// Group accumulator and fill counter for the averaging filter.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (clears acc and fill)
//   add   : add din into acc and increment fill
//   clr   : clear acc and fill (has priority over add)
//   din   : unsigned sample, DATA_W bits
//   acc   : running sum, DATA_W+LOG2_N bits (cannot overflow for N samples)
//   fill  : samples accumulated in the current group (0..N-1)
//   last  : fill is at N-1, so the next accepted sample completes the group
// -----------------------------------------------------------------------------
module iotdf_acc
   import iotdf_pkg::*;
#(
   parameter int DATA_W = IOTDF_DATA_W_DEF,
   parameter int LOG2_N = IOTDF_LOG2_N_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     add,
   input  logic                     clr,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W+LOG2_N-1:0] acc,
   output logic [LOG2_N-1:0]        fill,
   output logic                     last
);

   localparam int ACC_W = DATA_W + LOG2_N;
   // N-1 is all ones in LOG2_N bits.
   localparam logic [LOG2_N-1:0] FILL_MAX = '1;

   logic [ACC_W-1:0]  acc_reg;
   logic [LOG2_N-1:0] fill_reg;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc_reg  <= '0;
         fill_reg <= '0;
      end else if (add) begin
         acc_reg  <= acc_reg + ACC_W'(din);
         fill_reg <= fill_reg + LOG2_N'(1);
      end
   end

   assign acc  = acc_reg;
   assign fill = fill_reg;
   assign last = (fill_reg == FILL_MAX);

endmodule : iotdf_acc

// File: rtl/iotdf_avg_filter.sv
// -----------------------------------------------------------------------------
// iotdf_avg_filter
// Averages groups of N = 2^LOG2_N unsigned samples and emits one result per
// completed group, one cycle after the group's last sample is accepted.
// Build option: define IOTDF_AVG_ROUND_EN for round-half-up results;
// otherwise the average is truncated.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, overrides everything
//   en        : filter enable; low freezes all state
//   flush     : discard the partial group (sample in the same cycle dropped)
//   in_valid  : in_data carries a sample this cycle
//   in_data   : unsigned sample, DATA_W bits
//   out_valid : one-cycle pulse, out_data holds a new result
//   out_data  : last group average, held between pulses
//   fill      : samples accepted in the current group
//   group_cnt : completed groups, wraps 255 -> 0
// -----------------------------------------------------------------------------
module iotdf_avg_filter
   import iotdf_pkg::*;
#(
   parameter int DATA_W = IOTDF_DATA_W_DEF,
   parameter int LOG2_N = IOTDF_LOG2_N_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    flush,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output logic [LOG2_N-1:0]       fill,
   output logic [IOTDF_GCNT_W-1:0] group_cnt
);

   localparam int ACC_W = DATA_W + LOG2_N;

   logic [ACC_W-1:0]        acc;
   logic                    last;
   logic                    accept;
   logic                    complete;
   logic                    acc_add;
   logic                    acc_clr;
   logic [ACC_W-1:0]        sum;
   logic [DATA_W-1:0]       avg_next;

   logic                    out_valid_reg;
   logic [DATA_W-1:0]       out_data_reg;
   logic [IOTDF_GCNT_W-1:0] group_cnt_reg;

   // A flush takes precedence over a same-cycle sample, which is dropped.
   assign accept   = en & in_valid & ~flush;
   assign complete = accept & last;
   assign acc_add  = accept & ~last;
   // Completing a group restarts the accumulator so the very next sample
   // opens a fresh group.
   assign acc_clr  = (en & flush) | complete;

   // Sum including the sample that completes the group.
   assign sum = acc + ACC_W'(in_data);

`ifdef IOTDF_AVG_ROUND_EN
   // One extra bit so adding the half-LSB can never wrap.
   localparam int              RND_W = ACC_W + 1;
   localparam logic [RND_W-1:0] HALF  = RND_W'(1) << (LOG2_N - 1);

   logic [RND_W-1:0] sum_rnd;
   logic             unused_rnd_bits;

   assign sum_rnd  = RND_W'(sum) + HALF;
   assign avg_next = sum_rnd[LOG2_N +: DATA_W];
   // Fraction bits are discarded; the top bit is provably zero because the
   // rounded quotient never exceeds 2^DATA_W-1.
   assign unused_rnd_bits = ^{sum_rnd[RND_W-1], sum_rnd[LOG2_N-1:0]};
`else
   logic unused_frac_bits;

   assign avg_next = sum[LOG2_N +: DATA_W];
   // Fraction bits are discarded by truncation.
   assign unused_frac_bits = ^sum[LOG2_N-1:0];
`endif

   iotdf_acc #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
   ) u_acc (
      .clk  (clk),
      .rst  (rst),
      .add  (acc_add),
      .clr  (acc_clr),
      .din  (in_data),
      .acc  (acc),
      .fill (fill),
      .last (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         group_cnt_reg <= '0;
      end else begin
         // complete already requires en, so the pulse drops when en is low.
         out_valid_reg <= complete;
         if (complete) begin
            out_data_reg  <= avg_next;
            group_cnt_reg <= group_cnt_reg + IOTDF_GCNT_W'(1);
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign group_cnt = group_cnt_reg;

endmodule : iotdf_avg_filter

// File: tb/tb_iotdf_avg_filter.sv
// -----------------------------------------------------------------------------
// tb_iotdf_avg_filter
// Directed self-checking bench for iotdf_avg_filter (DATA_W=128, LOG2_N=3).
// Expected values are hand-computed; the ramp-average expectation follows the
// IOTDF_AVG_ROUND_EN build option.
// -----------------------------------------------------------------------------
module tb_iotdf_avg_filter;

   localparam int DATA_W = 128;
   localparam int LOG2_N = 3;

`ifdef IOTDF_AVG_ROUND_EN
   localparam logic [DATA_W-1:0] RAMP_AVG = 128'd5;
`else
   localparam logic [DATA_W-1:0] RAMP_AVG = 128'd4;
`endif
   localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              flush;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [LOG2_N-1:0] fill;
   logic [7:0]        group_cnt;

   int checks    = 0;
   int passes    = 0;
   int pulse_cnt = 0;

   iotdf_avg_filter #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .fill      (fill),
      .group_cnt (group_cnt)
   );

   always #5 clk = ~clk;

   // One clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) pulse_cnt++;
   endtask

   task automatic send(input logic [DATA_W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
      $display("txn: sample %0h -> fill=%0d out_valid=%0b out_data=%0h group_cnt=%0d", d, fill, out_valid, out_data, group_cnt);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 128'h55;
      step(); step();
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", out_valid); else passes++;
      checks++; if (out_data !== '0) $display("FAIL reset_data: got %0h expected 0", out_data); else passes++;
      checks++; if (fill !== 3'd0) $display("FAIL reset_fill: got %0d expected 0", fill); else passes++;
      checks++; if (group_cnt !== 8'd0) $display("FAIL reset_gcnt: got %0d expected 0", group_cnt); else passes++;
   endtask

   task automatic test_basic();
      pulse_cnt = 0;
      for (int i = 0; i < 7; i++) send(128'h10);
      checks++; if (fill !== 3'd7) $display("FAIL basic_fill7: got %0d expected 7", fill); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %0b expected 0", out_valid); else passes++;
      send(128'h10);
      checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %0b expected 1", out_valid); else passes++;
      checks++; if (out_data !== 128'h10) $display("FAIL basic_data: got %0h expected 10", out_data); else passes++;
      checks++; if (group_cnt !== 8'd1) $display("FAIL basic_gcnt: got %0d expected 1", group_cnt); else passes++;
      checks++; if (fill !== 3'd0) $display("FAIL basic_fill0: got %0d expected 0", fill); else passes++;
      idle();
      checks++; if (out_valid !== 1'b0) $display("FAIL basic_pulse_len: got %0b expected 0", out_valid); else passes++;
      checks++; if (out_data !== 128'h10) $display("FAIL basic_hold: got %0h expected 10", out_data); else passes++;
      checks++; if (pulse_cnt !== 1) $display("FAIL basic_pulses: got %0d expected 1", pulse_cnt); else passes++;
   endtask

   task automatic test_ramp();
      for (int i = 1; i <= 8; i++) send(DATA_W'(i));
      checks++; if (out_valid !== 1'b1) $display("FAIL ramp_valid: got %0b expected 1", out_valid); else passes++;
      checks++; if (out_data !== RAMP_AVG) $display("FAIL ramp_data: got %0h expected %0h", out_data, RAMP_AVG); else passes++;
      checks++; if (group_cnt !== 8'd2) $display("FAIL ramp_gcnt: got %0d expected 2", group_cnt); else passes++;
      idle();
   endtask

   task automatic test_all_ones();
      for (int i = 0; i < 8; i++) send(ALL_ONES);
      checks++; if (out_data !== ALL_ONES) $display("FAIL ones_data: got %0h expected %0h", out_data, ALL_ONES); else passes++;
      checks++; if (group_cnt !== 8'd3) $display("FAIL ones_gcnt: got %0d expected 3", group_cnt); else passes++;
      idle();
   endtask

   task automatic test_flush();
      pulse_cnt = 0;
      for (int i = 0; i < 3; i++) send(128'hFF);
      flush = 1'b1;
      send(128'hFF);
      flush = 1'b0;
      checks++; if (fill !== 3'd0) $display("FAIL flush_fill: got %0d expected 0", fill); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %0b expected 0", out_valid); else passes++;
      checks++; if (out_data !== ALL_ONES) $display("FAIL flush_hold: got %0h expected %0h", out_data, ALL_ONES); else passes++;
      checks++; if (group_cnt !== 8'd3) $display("FAIL flush_gcnt_hold: got %0d expected 3", group_cnt); else passes++;
      for (int i = 0; i < 8; i++) send(128'd2);
      idle();
      checks++; if (out_data !== 128'd2) $display("FAIL flush_data: got %0h expected 2", out_data); else passes++;
      checks++; if (group_cnt !== 8'd4) $display("FAIL flush_gcnt: got %0d expected 4", group_cnt); else passes++;
      checks++; if (pulse_cnt !== 1) $display("FAIL flush_pulses: got %0d expected 1", pulse_cnt); else passes++;
   endtask

   task automatic test_gaps();
      send(128'd1); idle(); send(128'd2); send(128'd3); idle(); idle();
      checks++; if (fill !== 3'd3) $display("FAIL gaps_fill3: got %0d expected 3", fill); else passes++;
      // Disabled: samples and flushes alike must be ignored.
      en = 1'b0; in_valid = 1'b1; in_data = 128'd100;
      for (int i = 0; i < 4; i++) begin
         flush = i[0];
         step();
         $display("txn: en=0 flush=%0b -> fill=%0d out_valid=%0b", flush, fill, out_valid);
         checks++; if (fill !== 3'd3) $display("FAIL gaps_en0_fill: got %0d expected 3", fill); else passes++;
      end
      en = 1'b1; flush = 1'b0; in_valid = 1'b0;
      send(128'd4); idle(); send(128'd5); send(128'd6); idle(); send(128'd7);
      checks++; if (fill !== 3'd7) $display("FAIL gaps_fill7: got %0d expected 7", fill); else passes++;
      send(128'd8);
      checks++; if (out_valid !== 1'b1) $display("FAIL gaps_valid: got %0b expected 1", out_valid); else passes++;
      checks++; if (out_data !== RAMP_AVG) $display("FAIL gaps_data: got %0h expected %0h", out_data, RAMP_AVG); else passes++;
      checks++; if (group_cnt !== 8'd5) $display("FAIL gaps_gcnt: got %0d expected 5", group_cnt); else passes++;
      idle();
   endtask

   task automatic test_back_to_back();
      pulse_cnt = 0;
      for (int i = 0; i < 8; i++) send(128'd1);
      checks++; if (out_data !== 128'd1) $display("FAIL b2b_data1: got %0h expected 1", out_data); else passes++;
      send(128'd3);
      checks++; if (fill !== 3'd1) $display("FAIL b2b_fill1: got %0d expected 1", fill); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL b2b_valid_drop: got %0b expected 0", out_valid); else passes++;
      for (int i = 0; i < 7; i++) send(128'd3);
      checks++; if (out_data !== 128'd3) $display("FAIL b2b_data2: got %0h expected 3", out_data); else passes++;
      checks++; if (group_cnt !== 8'd7) $display("FAIL b2b_gcnt: got %0d expected 7", group_cnt); else passes++;
      checks++; if (pulse_cnt !== 2) $display("FAIL b2b_pulses: got %0d expected 2", pulse_cnt); else passes++;
      idle();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) send(128'd9);
      checks++; if (fill !== 3'd5) $display("FAIL rmid_fill5: got %0d expected 5", fill); else passes++;
      rst = 1'b1; in_valid = 1'b1; in_data = 128'd9;
      step();
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (fill !== 3'd0) $display("FAIL rmid_fill: got %0d expected 0", fill); else passes++;
      checks++; if (out_data !== '0) $display("FAIL rmid_data: got %0h expected 0", out_data); else passes++;
      checks++; if (group_cnt !== 8'd0) $display("FAIL rmid_gcnt: got %0d expected 0", group_cnt); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %0b expected 0", out_valid); else passes++;
      for (int i = 0; i < 8; i++) send(128'd8);
      checks++; if (out_data !== 128'd8) $display("FAIL rmid_avg: got %0h expected 8", out_data); else passes++;
      checks++; if (group_cnt !== 8'd1) $display("FAIL rmid_gcnt1: got %0d expected 1", group_cnt); else passes++;
      // Reset coinciding with the completing sample wins over the result.
      for (int i = 0; i < 7; i++) send(128'd6);
      rst = 1'b1;
      send(128'd6);
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("FAIL rpend_valid: got %0b expected 0", out_valid); else passes++;
      checks++; if (out_data !== '0) $display("FAIL rpend_data: got %0h expected 0", out_data); else passes++;
      checks++; if (group_cnt !== 8'd0) $display("FAIL rpend_gcnt: got %0d expected 0", group_cnt); else passes++;
   endtask

   task automatic test_wrap();
      rst = 1'b1; step(); rst = 1'b0;
      pulse_cnt = 0;
      for (int g = 0; g < 255; g++)
         for (int i = 0; i < 8; i++) send(DATA_W'(g));
      checks++; if (group_cnt !== 8'd255) $display("FAIL wrap_255: got %0d expected 255", group_cnt); else passes++;
      checks++; if (out_data !== 128'd254) $display("FAIL wrap_data: got %0h expected fe", out_data); else passes++;
      for (int i = 0; i < 8; i++) send(128'd7);
      checks++; if (group_cnt !== 8'd0) $display("FAIL wrap_0: got %0d expected 0", group_cnt); else passes++;
      idle();
      checks++; if (pulse_cnt !== 256) $display("FAIL wrap_pulses: got %0d expected 256", pulse_cnt); else passes++;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      test_reset();
      test_basic();
      test_ramp();
      test_all_ones();
      test_flush();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_iotdf_avg_filter
